// File: rtl/addsub_pkg.sv
// Shared FSM state encoding and mode constants for the sequential add/sub unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder slice; cmsb is the carry into its top bit.
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    // Carry into the top bit recovered from that bit's sum; valid for SLICE=1 too.
    assign cmsb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: SLICE bits per cycle, LSB first,
// with valid/ready handshakes and C/V/N/Z flags.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic [KW-1:0]    k;
    logic             carry, c_r, v_r, z_r;
    logic [SLICE-1:0] sa, sb, ssum;
    logic             scout, scmsb, last;

    assign sa   = a_r[int'(k)*SLICE +: SLICE];
    assign sb   = b_r[int'(k)*SLICE +: SLICE];
    assign last = (k == K_LAST);

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a    (sa),
        .b    (sb),
        .cin  (carry),
        .sum  (ssum),
        .cout (scout),
        .cmsb (scmsb)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_CALC;
            end
            ST_CALC: if (last) state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            k     <= '0;
            carry <= 1'b0;
            c_r   <= 1'b0;
            v_r   <= 1'b0;
            z_r   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    // Subtraction folds into an add of ~b with carry-in 1.
                    a_r   <= a;
                    b_r   <= b ^ {WIDTH{m == MODE_SUB}};
                    carry <= m;
                    k     <= '0;
                    z_r   <= 1'b1;
                end
                ST_CALC: begin
                    s_r[int'(k)*SLICE +: SLICE] <= ssum;
                    carry <= scout;
                    z_r   <= z_r & (ssum == '0);
                    if (last) begin
                        c_r <= scout;
                        v_r <= scmsb ^ scout;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s = s_r;
    assign c = c_r;
    assign v = v_r;
    assign n = s_r[WIDTH-1];
    assign z = z_r;

endmodule

// File: tb/tb_addsub_seq.sv
// Lockstep bench for addsub_seq at SLICE=4, 16 and 1 (WIDTH=16): directed table,
// backpressure, mid-operation reset and random ops against a behavioural model.
module tb_addsub_seq;

    typedef struct packed {
        logic [15:0] s;
        logic        c, v, n, z;
    } res_t;

    typedef struct {
        logic [15:0] a, b;
        logic        m;
        res_t        r;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              m = 1'b0;
    logic [15:0]       a = '0, b = '0;
    logic [2:0]        in_ready, out_valid, c, v, n, z;
    logic [2:0][15:0]  s;

    int   n_chk = 0;
    int   n_fail = 0;
    int   nsl[3] = '{4, 1, 16};
    bit   seen[3];
    int   lat[3];
    res_t exp_q[$];
    vec_t tbl[7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SL = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        addsub_seq #(.WIDTH(16), .SLICE(SL)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .m         (m),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .s         (s[g]),
            .c         (c[g]),
            .v         (v[g]),
            .n         (n[g]),
            .z         (z[g])
        );
    end

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic md);
        res_t        r;
        logic [16:0] t;
        t   = md ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r.s = t[15:0];
        r.c = md ? (x >= y) : t[16];
        r.v = md ? ((x[15] != y[15]) && (r.s[15] != x[15]))
                 : ((x[15] == y[15]) && (r.s[15] != x[15]));
        r.n = r.s[15];
        r.z = (r.s == 16'h0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_res(input int g, input res_t e, input string tag);
        chk($sformatf("%s[%0d].s", tag, g), 32'(s[g]), 32'(e.s));
        chk($sformatf("%s[%0d].c", tag, g), 32'(c[g]), 32'(e.c));
        chk($sformatf("%s[%0d].v", tag, g), 32'(v[g]), 32'(e.v));
        chk($sformatf("%s[%0d].n", tag, g), 32'(n[g]), 32'(e.n));
        chk($sformatf("%s[%0d].z", tag, g), 32'(z[g]), 32'(e.z));
    endtask

    // Drive one op to all three instances, check latency and result, hold for
    // bp cycles of backpressure, then release with a single transfer.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic md,
                          input res_t e, input bit junk, input int bp, input string tag);
        res_t got;
        bit   all;
        @(negedge clk);
        a = x; b = y; m = md; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (junk) begin
            a = 16'($urandom); b = 16'($urandom); m = 1'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        for (int g = 0; g < 3; g++) begin
            seen[g] = 1'b0;
            lat[g]  = 0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            all = 1'b1;
            for (int g = 0; g < 3; g++) begin
                if (!seen[g] && out_valid[g]) begin
                    seen[g] = 1'b1;
                    lat[g]  = cyc;
                end
                all &= seen[g];
            end
            if (all) break;
        end
        got = exp_q.pop_front();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s[%0d].latency", tag, g), 32'(lat[g]), 32'(nsl[g]));
            check_res(g, got, tag);
        end
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) begin
                check_res(g, got, {tag, ".hold"});
                chk($sformatf("%s[%0d].hold_in_ready", tag, g), 32'(in_ready[g]), 32'd0);
                chk($sformatf("%s[%0d].hold_out_valid", tag, g), 32'(out_valid[g]), 32'd1);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s[%0d].post_out_valid", tag, g), 32'(out_valid[g]), 32'd0);
            chk($sformatf("%s[%0d].post_in_ready", tag, g), 32'(in_ready[g]), 32'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[1] = '{16'h1234, 16'h1234, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        tbl[2] = '{16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        tbl[4] = '{16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst[%0d].in_ready", g), 32'(in_ready[g]), 32'd1);
            chk($sformatf("rst[%0d].out_valid", g), 32'(out_valid[g]), 32'd0);
            check_res(g, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}, "rst");
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].r, 1'b0, 0, $sformatf("tbl%0d", i));

        // Backpressure: 10 held cycles in DONE, then one transfer.
        run_op(16'h8000, 16'h8000, 1'b0, tbl[6].r, 1'b0, 10, "bp");

        // Operands changing with in_valid held during CALC/DONE must be ignored.
        run_op(16'h1234, 16'h0FFF, 1'b0, model(16'h1234, 16'h0FFF, 1'b0), 1'b1, 0, "junk");

        // Reset at CALC k=2 (SLICE=4); SLICE=16 is in DONE, SLICE=1 mid-CALC.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("midrst[%0d].in_ready", g), 32'(in_ready[g]), 32'd1);
            chk($sformatf("midrst[%0d].out_valid", g), 32'(out_valid[g]), 32'd0);
            chk($sformatf("midrst[%0d].z", g), 32'(z[g]), 32'd1);
            chk($sformatf("midrst[%0d].s", g), 32'(s[g]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(16'h0003, 16'h0005, 1'b1, tbl[4].r, 1'b0, 0, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] x, y;
            logic        md;
            x  = 16'($urandom);
            y  = 16'($urandom);
            md = 1'($urandom);
            if (($urandom % 8) == 0) x = y;
            run_op(x, y, md, model(x, y, md), ($urandom % 4) == 0,
                   (($urandom % 8) == 0) ? 2 : 0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
